// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for common-anode 7-segment digits on a shared active-low bus
//   clk    system clock
//   rst    asynchronous active-high reset
//   load   one-cycle strobe capturing data/dp/blank/blink into the shadow register
//   data   4-bit glyph code per digit, digit k in [4k+3:4k]
//   dp     per-digit decimal point
//   blank  per-digit force dark
//   blink  per-digit blink enable
//   seg    {dp,g,f,e,d,c,b,a}, active-low, registered
//   dig    one-hot digit select at SEL_ACTIVE_LOW polarity, registered
//   frame  one-cycle pulse after the active register commits
module seg7_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV = 50000,
   parameter int GUARD = 2,
   parameter int BLINK_DIV = 12500000,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig,
   output logic                    frame
);
   localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam int SW = 7 * NUM_DIGITS;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
   // Register image packed as {blink, blank, dp, data}; reset state is all digits blanked.
   localparam logic [SW-1:0] REG_RST = {{NUM_DIGITS{1'b0}}, {NUM_DIGITS{1'b1}}, {5*NUM_DIGITS{1'b0}}};
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [BW-1:0] bcnt;
   logic phase;
   logic [SW-1:0] shadow, active, in_v;
   logic [4*NUM_DIGITS-1:0] ac_data, data_sh;
   logic [NUM_DIGITS-1:0] ac_dp, ac_blank, ac_blink, one, dig_n;
   logic slot_end, boundary, guard, dark;
   logic [3:0] glyph;
   logic [6:0] dec;
   logic [7:0] seg_n;
   always_comb begin
      in_v = {blink, blank, dp, data};
      {ac_blink, ac_blank, ac_dp, ac_data} = active;
      slot_end = cnt == CNT_MAX;
      boundary = slot_end && idx == IDX_MAX;
      guard = cnt < GUARD_C;
      one = NUM_DIGITS'(1) << idx;
      data_sh = ac_data >> {idx, 2'b00};
      glyph = data_sh[3:0];
      dark = |(one & ac_blank) || (|(one & ac_blink) && !phase);
      seg_n = guard || dark ? 8'hFF : {~|(one & ac_dp), dec};
      dig_n = guard ? '0 : one;
   end
   always_comb begin
      case (glyph)
         4'h0: dec = 7'b1000000;
         4'h1: dec = 7'b1111001;
         4'h2: dec = 7'b0100100;
         4'h3: dec = 7'b0110000;
         4'h4: dec = 7'b0011001;
         4'h5: dec = 7'b0010010;
         4'h6: dec = 7'b0000010;
         4'h7: dec = 7'b1111000;
         4'h8: dec = 7'b0000000;
         4'h9: dec = 7'b0011000;
         4'hA: dec = 7'b1000111;
         4'hB: dec = 7'b1000110;
         4'hC: dec = 7'b0110110;
         default: dec = 7'b1111111;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         bcnt <= '0;
         phase <= 1'b1;
         shadow <= REG_RST;
         active <= REG_RST;
         seg <= 8'hFF;
         dig <= SEL_OFF;
         frame <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + CW'(1);
         if (slot_end) idx <= idx == IDX_MAX ? '0 : idx + IW'(1);
         bcnt <= bcnt == BLK_MAX ? '0 : bcnt + BW'(1);
         if (bcnt == BLK_MAX) phase <= ~phase;
         if (load) shadow <= in_v;
         // A load landing on the boundary itself bypasses the shadow so it is not lost for a frame.
         if (boundary) active <= load ? in_v : shadow;
         frame <= boundary;
         seg <= seg_n;
         dig <= dig_n ^ SEL_OFF;
      end
   end
endmodule
